// File: rtl/netlist_vector_sequencer.sv
// Drives a combinational netlist with LFSR vectors, waits a settle time per vector,
// and compacts the captured netlist outputs into a MISR signature.
module netlist_vector_sequencer #(
    parameter int                 IN_W       = 14,
    parameter int                 OUT_W      = 8,
    parameter int                 SETTLE_CYC = 2,
    parameter logic [IN_W-1:0]    LFSR_TAPS  = 14'h2015,
    parameter logic [OUT_W-1:0]   MISR_TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      num_vec,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_cnt,
    output logic [OUT_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q, lfsr_d;
    logic [OUT_W-1:0]  misr_q, misr_d;
    logic [15:0]       vec_cnt_q, vec_cnt_d;
    logic [15:0]       num_vec_q, num_vec_d;
    logic [3:0]        settle_q, settle_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            misr_q    <= '0;
            vec_cnt_q <= '0;
            num_vec_q <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            vec_cnt_q <= vec_cnt_d;
            num_vec_q <= num_vec_d;
            settle_q  <= settle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        vec_cnt_d = vec_cnt_q;
        num_vec_d = num_vec_q;
        settle_d  = settle_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    misr_d    = '0;
                    vec_cnt_d = '0;
                    settle_d  = '0;
                    num_vec_d = num_vec;
                    if (num_vec == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        // An all-zero LFSR would lock up, so a zero seed becomes 1
                        lfsr_d  = (seed == '0) ? IN_W'(1) : seed;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    misr_d    = {misr_q[OUT_W-2:0], ^(misr_q & MISR_TAPS)} ^ dut_out;
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    lfsr_d    = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                    state_d   = (vec_cnt_d == num_vec_q) ? DONE : SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = !abort;
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy also covers the DONE cycle of a real run so done rises the cycle busy falls;
    // an empty run (IDLE straight to DONE) never raises busy.
    always_comb begin
        busy_d = (state_d == SETTLE) || (state_d == CAPTURE) ||
                 ((state_d == DONE) && (state_q == CAPTURE));
    end

    assign dut_in    = lfsr_q;
    assign signature = misr_q;
    assign vec_cnt   = vec_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_netlist_vector_sequencer.sv
// Directed self-checking bench for netlist_vector_sequencer with a wire-through
// and a small combinational netlist model on dut_out.
module tb_netlist_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_vec;
    logic [13:0] seed;
    logic [13:0] dut_in;
    logic [7:0]  dut_out;
    logic        busy;
    logic        done;
    logic [15:0] vec_cnt;
    logic [7:0]  signature;
    logic        useNet;

    int checks = 0;
    int errors = 0;

    int          doneAt;
    int          busyCnt;
    int          doneCnt;
    bit          sawZero;
    logic [13:0] firstIn;
    logic [13:0] expIn;
    logic [7:0]  expSig;
    logic [13:0] rndSeed;

    netlist_vector_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .seed      (seed),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .vec_cnt   (vec_cnt),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] netFn(input logic [13:0] x);
        logic [7:0] r;
        r    = (x[7:0] ^ {x[13:8], x[1:0]}) + {x[5:0], x[13:12]};
        r[4] = r[4] ^ (x[12] & x[3]);
        return r;
    endfunction

    always_comb dut_out = useNet ? netFn(dut_in) : dut_in[7:0];

    function automatic logic [13:0] lfsrStep(input logic [13:0] x);
        return {x[12:0], ^(x & 14'h2015)};
    endfunction

    function automatic logic [7:0] misrStep(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], ^(m & 8'hB8)} ^ d;
    endfunction

    task automatic modelRun(input logic [13:0] s, input int n, input bit net,
                            output logic [7:0] sig, output logic [13:0] lastIn);
        logic [13:0] v;
        logic [7:0]  m;
        v = (s == 14'd0) ? 14'd1 : s;
        m = 8'd0;
        for (int i = 0; i < n; i++) begin
            m = misrStep(m, net ? netFn(v) : v[7:0]);
            v = lfsrStep(v);
        end
        sig    = m;
        lastIn = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start and follows the run until done; k counts cycles after the start edge.
    task automatic applyStimulus(input logic [15:0] n, input logic [13:0] s, input bit noisy);
        num_vec = n;
        seed    = s;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        doneAt  = -1;
        busyCnt = 0;
        sawZero = 1'b0;
        firstIn = dut_in;
        for (int k = 0; k < 20000; k++) begin
            if (busy) busyCnt++;
            if (busy && dut_in == 14'd0) sawZero = 1'b1;
            if (done) begin
                doneAt = k;
                break;
            end
            if (noisy) begin
                start   = (k % 4 == 1);
                seed    = 14'h3FFF - 14'(k);
                num_vec = 16'd2;
            end
            tick();
        end
        start   = 1'b0;
        num_vec = n;
        seed    = s;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        num_vec = 16'd0;
        seed    = 14'd0;
        useNet  = 1'b0;
        #12;
        checkOutput("rst_dut_in", dut_in, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_vec_cnt", vec_cnt, 0);
        checkOutput("rst_signature", signature, 0);
        #4 rst_n = 1'b1;
        tick();

        // Wire-through, seed 1, one vector
        applyStimulus(16'd1, 14'd1, 1'b0);
        checkOutput("a_first_in", firstIn, 14'h0001);
        checkOutput("a_done_at", doneAt, 4);
        checkOutput("a_busy_cycles", busyCnt, 4);
        checkOutput("a_busy_at_done", busy, 0);
        checkOutput("a_signature", signature, 8'h01);
        checkOutput("a_vec_cnt", vec_cnt, 1);
        checkOutput("a_dut_in", dut_in, 14'h0003);
        tick();
        checkOutput("a_done_one_cycle", done, 0);

        // Zero seed becomes 1; three vectors 0001, 0003, 0007
        applyStimulus(16'd3, 14'd0, 1'b0);
        checkOutput("b_first_in", firstIn, 14'h0001);
        checkOutput("b_done_at", doneAt, 10);
        checkOutput("b_signature", signature, 8'h05);
        checkOutput("b_vec_cnt", vec_cnt, 3);
        checkOutput("b_dut_in", dut_in, 14'h000E);
        tick();

        // Empty run
        applyStimulus(16'd0, 14'h0155, 1'b0);
        checkOutput("c_done_at", doneAt, 1);
        checkOutput("c_busy_cycles", busyCnt, 0);
        checkOutput("c_signature", signature, 0);
        checkOutput("c_vec_cnt", vec_cnt, 0);
        tick();

        // Abort in the second SETTLE of a five-vector run
        num_vec = 16'd5;
        seed    = 14'h1234;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("d_busy_before_abort", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("d_busy_after_abort", busy, 0);
        checkOutput("d_vec_cnt", vec_cnt, 1);
        checkOutput("d_signature", signature, 8'h34);
        checkOutput("d_dut_in", dut_in, 14'h2468);
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) doneCnt++;
            tick();
        end
        checkOutput("d_no_done", doneCnt, 0);
        applyStimulus(16'd5, 14'h1234, 1'b0);
        modelRun(14'h1234, 5, 1'b0, expSig, expIn);
        checkOutput("d_rerun_done_at", doneAt, 16);
        checkOutput("d_rerun_signature", signature, expSig);
        checkOutput("d_rerun_vec_cnt", vec_cnt, 5);
        tick();

        // Asynchronous reset during CAPTURE
        num_vec = 16'd4;
        seed    = 14'h0ABC;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("e_rst_dut_in", dut_in, 0);
        checkOutput("e_rst_busy", busy, 0);
        checkOutput("e_rst_done", done, 0);
        checkOutput("e_rst_vec_cnt", vec_cnt, 0);
        checkOutput("e_rst_signature", signature, 0);
        #3 rst_n = 1'b1;
        tick();
        applyStimulus(16'd6, 14'h0ABC, 1'b1);
        modelRun(14'h0ABC, 6, 1'b0, expSig, expIn);
        checkOutput("e_done_at", doneAt, 19);
        checkOutput("e_signature", signature, expSig);
        checkOutput("e_vec_cnt", vec_cnt, 6);
        checkOutput("e_dut_in", dut_in, expIn);
        tick();

        // Netlist model, random seeds, long runs
        useNet = 1'b1;
        for (int r = 0; r < 3; r++) begin
            rndSeed = 14'($urandom_range(0, 16383));
            applyStimulus(16'd1000, rndSeed, 1'b0);
            modelRun(rndSeed, 1000, 1'b1, expSig, expIn);
            checkOutput("f_done_at", doneAt, 3001);
            checkOutput("f_signature", signature, expSig);
            checkOutput("f_vec_cnt", vec_cnt, 1000);
            checkOutput("f_dut_in", dut_in, expIn);
            checkOutput("f_never_zero", sawZero, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
